// File: rtl/instruction_fetch.sv
// Fetch sequencer: one outstanding read at PC, holds the instruction for decode under valid/ready,
// applies absolute/relative redirects with a one-cycle settle; optional FETCH_COUNT_EN delivered-instruction counter.
module instruction_fetch #(
    parameter logic [7:0] INC_STEP   = 8'h01,
    parameter int         DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           PC,
    output logic                  PcIncrement,
    output logic [7:0]            PcIn,
    output logic [15:0]           PcImm,
    output logic                  PcWriteEnable,
    output logic                  MemReq,
    output logic [15:0]           MemAddr,
    input  logic                  MemAck,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic [DATA_WIDTH-1:0] InstrOut,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    input  logic                  BranchTaken,
    input  logic [7:0]            BranchDisp,
    input  logic                  Redirect,
    input  logic [15:0]           RedirectTarget,
    output logic [15:0]           FetchCount
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= FETCH;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Redirects win over everything, including an ack arriving in the same cycle.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        PcIncrement   = 1'b0;
        PcIn          = 8'h00;
        PcImm         = 16'h0000;
        PcWriteEnable = 1'b0;
        if (Reset) begin
            if (Redirect) begin
                PcWriteEnable = 1'b1;
                PcImm         = RedirectTarget;
                valid_d       = 1'b0;
                state_d       = SETTLE;
            end else if (BranchTaken) begin
                PcIncrement = 1'b1;
                PcIn        = BranchDisp;
                valid_d     = 1'b0;
                state_d     = SETTLE;
            end else begin
                case (state_q)
                    FETCH: begin
                        if (MemAck) begin
                            instr_d     = MemData;
                            valid_d     = 1'b1;
                            state_d     = HOLD;
                            PcIncrement = 1'b1;
                            PcIn        = INC_STEP;
                        end
                    end
                    HOLD: begin
                        if (InstrReady) begin
                            valid_d = 1'b0;
                            state_d = FETCH;
                        end
                    end
                    SETTLE:  state_d = FETCH;
                    default: state_d = FETCH;
                endcase
            end
        end
    end

    assign MemReq     = Reset && (state_q == FETCH);
    assign MemAddr    = PC;
    assign InstrOut   = instr_q;
    assign InstrValid = valid_q;

`ifdef FETCH_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (valid_q && InstrReady && !Redirect && !BranchTaken) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign FetchCount = count_q;
`else
    assign FetchCount = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random cycles against a transaction-level model.
module tb_instruction_fetch;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] PC = 16'h0000;
    logic        PcIncrement, PcWriteEnable, MemReq, InstrValid;
    logic [7:0]  PcIn;
    logic [15:0] PcImm, MemAddr, InstrOut, FetchCount;
    logic        MemAck = 1'b0, InstrReady = 1'b0, BranchTaken = 1'b0, Redirect = 1'b0;
    logic [15:0] MemData = 16'h0000, RedirectTarget = 16'h0000;
    logic [7:0]  BranchDisp = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the fetch pipeline: what instruction is waiting for decode, whether we are settling,
    // where the PC should be and how many instructions decode has taken.
    bit          m_holding = 0;
    bit          m_settling = 0;
    logic [15:0] m_instr = 16'h0000;
    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_delivered = 16'h0000;

    instruction_fetch dut (
        .Clock(Clock), .Reset(Reset), .PC(PC),
        .PcIncrement(PcIncrement), .PcIn(PcIn), .PcImm(PcImm), .PcWriteEnable(PcWriteEnable),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
        .InstrOut(InstrOut), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .BranchTaken(BranchTaken), .BranchDisp(BranchDisp),
        .Redirect(Redirect), .RedirectTarget(RedirectTarget), .FetchCount(FetchCount)
    );

    always #5 Clock = ~Clock;

    // Program counter environment, driven by the DUT's control outputs.
    always @(posedge Clock) begin
        if (!Reset)             PC <= 16'h0000;
        else if (PcWriteEnable) PC <= PcImm;
        else if (PcIncrement)   PC <= PC + {{8{PcIn[7]}}, PcIn};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic ack, input logic [15:0] data, input logic rdy,
                        input logic br, input logic [7:0] disp, input logic rd, input logic [15:0] tgt);
        logic        fetching, take;
        logic        e_inc, e_we;
        logic [7:0]  e_in;
        logic [15:0] e_imm;
        @(negedge Clock);
        Reset = rst; MemAck = ack; MemData = data; InstrReady = rdy;
        BranchTaken = br; BranchDisp = disp; Redirect = rd; RedirectTarget = tgt;
        #1;
        fetching = rst && !m_holding && !m_settling;
        take     = fetching && ack && !rd && !br;
        e_we     = rst && rd;
        e_imm    = e_we ? tgt : 16'h0000;
        e_inc    = rst && !rd && (br || take);
        e_in     = (!rst || rd) ? 8'h00 : br ? disp : take ? 8'h01 : 8'h00;
        check_eq("pc", PC, m_pc);
        check_eq("mem_req", MemReq, fetching);
        if (fetching) check_eq("mem_addr", MemAddr, m_pc);
        check_eq("instr_valid", InstrValid, m_holding);
        check_eq("instr_out", InstrOut, m_instr);
`ifdef FETCH_COUNT_EN
        check_eq("fetch_count", FetchCount, m_delivered);
`else
        check_eq("fetch_count", FetchCount, 16'h0000);
`endif
        check_eq("pc_we", PcWriteEnable, e_we);
        check_eq("pc_imm", PcImm, e_imm);
        check_eq("pc_inc", PcIncrement, e_inc);
        check_eq("pc_in", PcIn, e_in);
        @(posedge Clock);
        if (!rst) begin
            m_holding = 0; m_settling = 0; m_instr = 16'h0000; m_pc = 16'h0000; m_delivered = 16'h0000;
        end else if (rd || br) begin
            m_pc       = rd ? tgt : m_pc + {{8{disp[7]}}, disp};
            m_holding  = 0;
            m_settling = 1;
        end else if (m_settling) begin
            m_settling = 0;
        end else if (m_holding) begin
            if (rdy) begin
                m_holding   = 0;
                m_delivered = m_delivered + 16'd1;
            end
        end else if (ack) begin
            m_instr   = data;
            m_holding = 1;
            m_pc      = m_pc + 16'd1;
        end
    endtask

    initial begin
        // Reset, then the basic fetch with ack on the second FETCH cycle.
        step(0, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        step(0, 1, 16'hDEAD, 1, 1, 8'h05, 1, 16'h4444);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        step(1, 1, 16'hA5C3, 0, 0, 8'h00, 0, 16'h0000);
        for (int i = 0; i < 5; i++) step(1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        step(1, 0, 16'h0000, 1, 0, 8'h00, 0, 16'h0000);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        // Branch back by 4 while holding.
        step(1, 1, 16'h1111, 0, 0, 8'h00, 0, 16'h0000);
        step(1, 0, 16'h0000, 0, 1, 8'hFC, 0, 16'h0000);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        // Redirect and branch together with an ack in FETCH: ack discarded, redirect wins.
        step(1, 1, 16'hFFFF, 0, 1, 8'h10, 1, 16'h1234);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        // Reset while a request is outstanding.
        step(0, 1, 16'h7777, 0, 0, 8'h00, 0, 16'h0000);
        // Three delivered instructions plus one cancelled by a redirect during the accept.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 16'h2000 + 16'(i), 0, 0, 8'h00, 0, 16'h0000);
            step(1, 0, 16'h0000, 1, 0, 8'h00, 0, 16'h0000);
        end
        step(1, 1, 16'h3000, 0, 0, 8'h00, 0, 16'h0000);
        step(1, 0, 16'h0000, 1, 0, 8'h00, 1, 16'hFFFE);
        step(1, 0, 16'h0000, 0, 0, 8'h00, 0, 16'h0000);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 60) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, 8'($urandom),
                 $urandom_range(0, 9) == 0, 16'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
